// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the core/accelerator data-memory bus arbiter.
package mem_arb_pkg;

    typedef enum logic {IDLE, BUSY} arb_state_t;
    typedef enum logic {REQ_CORE, REQ_ACC} req_id_t;

    localparam logic [31:0] ARB_ABORT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// One memory-bus port: request fields flow master -> slave, rdata/valid flow back.
interface mem_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            cs;
    logic            rd_wr;
    logic [DW/8-1:0] mask;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW-1:0]   rdata;
    logic            valid;

    modport master (output cs, rd_wr, mask, addr, wdata, input rdata, valid);
    modport slave  (input cs, rd_wr, mask, addr, wdata, output rdata, valid);
endinterface

// File: rtl/mem_arb_rr_pick.sv
// Combinational two-way round-robin picker: on a tie the requester not granted last wins.
module mem_arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] reqs,
    input  req_id_t    last,
    output req_id_t    gnt_id,
    output logic       gnt_vld
);

    always_comb begin
        gnt_vld = |reqs;
        gnt_id  = REQ_CORE;
        case (reqs)
            2'b10:   gnt_id = REQ_ACC;
            2'b11:   gnt_id = (last == REQ_CORE) ? REQ_ACC : REQ_CORE;
            default: gnt_id = REQ_CORE;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the data-memory port between core (c) and accelerator (a), one transaction at a time.
// Optional watchdog abort enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    mem_bus_arbiter_if.slave  c,
    mem_bus_arbiter_if.slave  a,
    mem_bus_arbiter_if.master m,
    output logic              err
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]      state_q;
    req_id_t         last_q;
    req_id_t         winner_q;
    logic            cs_q;
    logic            rd_wr_q;
    logic [DW/8-1:0] mask_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;

    req_id_t         gnt_id;
    logic            gnt_vld;
    logic            busy;
    logic            abort;
    logic [DW-1:0]   resp_data;

    logic            sel_rd_wr;
    logic [DW/8-1:0] sel_mask;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;

    assign busy = (state_q == ST_BUSY);

    mem_arb_rr_pick u_pick (
        .reqs    ({a.cs, c.cs}),
        .last    (last_q),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [CW-1:0] cnt_q;
    logic          err_q;

    // m_valid in the final cycle takes priority over the abort.
    assign abort = busy && !m.valid && (cnt_q == CW'(TIMEOUT_CYC - 1));
    assign err   = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (!busy) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (abort) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign abort = 1'b0;
    assign err   = 1'b0;
`endif

    always_comb begin
        if (gnt_id == REQ_CORE) begin
            sel_rd_wr = c.rd_wr;
            sel_mask  = c.mask;
            sel_addr  = c.addr;
            sel_wdata = c.wdata;
        end else begin
            sel_rd_wr = a.rd_wr;
            sel_mask  = a.mask;
            sel_addr  = a.addr;
            sel_wdata = a.wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            last_q   <= REQ_ACC;
            winner_q <= REQ_CORE;
            cs_q     <= 1'b0;
            rd_wr_q  <= 1'b0;
            mask_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        state_q  <= ST_BUSY;
                        last_q   <= gnt_id;
                        winner_q <= gnt_id;
                        cs_q     <= 1'b1;
                        rd_wr_q  <= sel_rd_wr;
                        mask_q   <= sel_mask;
                        addr_q   <= sel_addr;
                        wdata_q  <= sel_wdata;
                    end
                end
                default: begin
                    if (m.valid || abort) begin
                        state_q <= ST_IDLE;
                        cs_q    <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign m.cs    = cs_q;
    assign m.rd_wr = rd_wr_q;
    assign m.mask  = mask_q;
    assign m.addr  = addr_q;
    assign m.wdata = wdata_q;

    assign resp_data = abort ? DW'(ARB_ABORT_DATA) : m.rdata;

    // Responses reach only the current winner; m_valid seen while idle is dropped.
    always_comb begin
        c.valid = 1'b0;
        c.rdata = '0;
        a.valid = 1'b0;
        a.rdata = '0;
        if (busy) begin
            if (winner_q == REQ_CORE) begin
                c.valid = m.valid || abort;
                c.rdata = resp_data;
            end else begin
                a.valid = m.valid || abort;
                a.rdata = resp_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a 2-cycle-latency memory model.
// Timeout scenario runs only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_bus_arbiter;

    localparam int TIMEOUT_CYC = 64;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic err;

    int pass_cnt = 0;
    int total_cnt = 0;

    mem_bus_arbiter_if #(.AW(32), .DW(32)) c_if ();
    mem_bus_arbiter_if #(.AW(32), .DW(32)) a_if ();
    mem_bus_arbiter_if #(.AW(32), .DW(32)) m_if ();

    mem_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .c       (c_if),
        .a       (a_if),
        .m       (m_if),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Memory model: captures on first edge seeing m_cs, pulses m_valid two cycles later.
    logic [31:0] mem [0:255];
    logic        mbusy;
    logic        mcnt;
    logic [7:0]  midx;
    logic        mem_hang = 1'b0;
    logic        spurious = 1'b0;
    int          txn_cnt;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mbusy      <= 1'b0;
            mcnt       <= 1'b0;
            midx       <= '0;
            m_if.valid <= 1'b0;
            m_if.rdata <= '0;
            txn_cnt    <= 0;
            mem[64]    <= 32'h1234_5678;
            mem[65]    <= 32'hA5A5_0001;
            mem[128]   <= 32'h1122_3344;
        end else begin
            m_if.valid <= spurious;
            if (!mbusy) begin
                if (m_if.cs) begin
                    mbusy   <= 1'b1;
                    mcnt    <= 1'b1;
                    midx    <= m_if.addr[9:2];
                    txn_cnt <= txn_cnt + 1;
                    if (m_if.rd_wr) begin
                        for (int b = 0; b < 4; b++) begin
                            if (m_if.mask[b]) mem[m_if.addr[9:2]][8*b +: 8] <= m_if.wdata[8*b +: 8];
                        end
                    end
                end
            end else if (mcnt) begin
                mcnt <= 1'b0;
                if (!mem_hang) begin
                    m_if.valid <= 1'b1;
                    m_if.rdata <= mem[midx];
                end
            end else if (!mem_hang) begin
                mbusy <= 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (!(c_if.valid || a_if.valid) && n < limit) begin
            step();
            n++;
        end
    endtask

    task automatic clear_inputs();
        c_if.cs = 0; c_if.rd_wr = 0; c_if.mask = 4'hF; c_if.addr = 0; c_if.wdata = 0;
        a_if.cs = 0; a_if.rd_wr = 0; a_if.mask = 4'hF; a_if.addr = 0; a_if.wdata = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if (m_if.cs !== 1'b0) $display("FAIL reset_m_cs: got %b exp 0", m_if.cs);
        else pass_cnt++;
        total_cnt++;
        if ({c_if.valid, a_if.valid, err} !== 3'b000)
            $display("FAIL reset_valid_err: got %b exp 000", {c_if.valid, a_if.valid, err});
        else pass_cnt++;
        total_cnt++;
        if (m_if.addr !== 32'h0) $display("FAIL reset_m_addr: got %h exp 0", m_if.addr);
        else pass_cnt++;
    endtask

    task automatic test_core_read();
        int n;
        c_if.cs = 1; c_if.rd_wr = 0; c_if.addr = 32'h100;
        total_cnt++;
        if (m_if.cs !== 1'b0) $display("FAIL cr_latency: got m_cs %b exp 0", m_if.cs);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({m_if.cs, m_if.addr} !== {1'b1, 32'h100})
            $display("FAIL cr_grant: got cs %b addr %h exp 1 100", m_if.cs, m_if.addr);
        else pass_cnt++;
        wait_valid(100, n);
        total_cnt++;
        if (n !== 2) $display("FAIL cr_wait: got %0d cycles exp 2", n);
        else pass_cnt++;
        total_cnt++;
        if ({c_if.valid, a_if.valid, c_if.rdata} !== {2'b10, 32'h1234_5678})
            $display("FAIL cr_resp: got cv %b av %b rd %h exp 1 0 12345678",
                     c_if.valid, a_if.valid, c_if.rdata);
        else pass_cnt++;
        c_if.cs = 0;
        step();
        total_cnt++;
        if ({m_if.cs, c_if.valid} !== 2'b00)
            $display("FAIL cr_release: got cs %b cv %b exp 0 0", m_if.cs, c_if.valid);
        else pass_cnt++;
    endtask

    task automatic test_tie();
        int n;
        do_reset();
        c_if.cs = 1; c_if.addr = 32'h100;
        a_if.cs = 1; a_if.addr = 32'h104;
        step();
        total_cnt++;
        if (m_if.addr !== 32'h100) $display("FAIL tie1_core_first: got addr %h exp 100", m_if.addr);
        else pass_cnt++;
        wait_valid(100, n);
        total_cnt++;
        if ({c_if.valid, a_if.valid} !== 2'b10)
            $display("FAIL tie1_valid: got cv %b av %b exp 1 0", c_if.valid, a_if.valid);
        else pass_cnt++;
        c_if.cs = 0;
        step();
        step();
        total_cnt++;
        if ({m_if.cs, m_if.addr} !== {1'b1, 32'h104})
            $display("FAIL tie2_acc_next: got cs %b addr %h exp 1 104", m_if.cs, m_if.addr);
        else pass_cnt++;
        wait_valid(100, n);
        total_cnt++;
        if ({a_if.valid, a_if.rdata, c_if.valid, c_if.rdata} !== {1'b1, 32'hA5A5_0001, 1'b0, 32'h0})
            $display("FAIL tie2_resp: got av %b ard %h cv %b crd %h exp 1 a5a50001 0 0",
                     a_if.valid, a_if.rdata, c_if.valid, c_if.rdata);
        else pass_cnt++;
        c_if.cs = 1;
        step();
        step();
        total_cnt++;
        if ({m_if.cs, m_if.addr} !== {1'b1, 32'h100})
            $display("FAIL tie3_core_again: got cs %b addr %h exp 1 100", m_if.cs, m_if.addr);
        else pass_cnt++;
        a_if.cs = 0;
        wait_valid(100, n);
        c_if.cs = 0;
        step();
    endtask

    task automatic test_acc_write();
        int n;
        a_if.cs = 1; a_if.rd_wr = 1; a_if.addr = 32'h200; a_if.wdata = 32'hCAFE_F00D; a_if.mask = 4'b0011;
        step();
        total_cnt++;
        if ({m_if.rd_wr, m_if.mask, m_if.wdata} !== {1'b1, 4'b0011, 32'hCAFE_F00D})
            $display("FAIL wr_latch: got wr %b mask %b data %h exp 1 0011 cafef00d",
                     m_if.rd_wr, m_if.mask, m_if.wdata);
        else pass_cnt++;
        a_if.addr = 32'h300; a_if.wdata = 32'h0; a_if.mask = 4'b1111;
        step();
        total_cnt++;
        if ({m_if.addr, m_if.mask} !== {32'h200, 4'b0011})
            $display("FAIL wr_hold: got addr %h mask %b exp 200 0011", m_if.addr, m_if.mask);
        else pass_cnt++;
        wait_valid(100, n);
        total_cnt++;
        if ({a_if.valid, c_if.valid} !== 2'b10)
            $display("FAIL wr_valid: got av %b cv %b exp 1 0", a_if.valid, c_if.valid);
        else pass_cnt++;
        a_if.cs = 0; a_if.rd_wr = 0;
        step();
        total_cnt++;
        if (mem[128] !== 32'h1122_F00D) $display("FAIL wr_mask: got mem %h exp 1122f00d", mem[128]);
        else pass_cnt++;
    endtask

    task automatic test_idle_valid();
        spurious = 1;
        step();
        total_cnt++;
        if ({m_if.valid, c_if.valid, a_if.valid, m_if.cs} !== 4'b1000)
            $display("FAIL idle_valid: got mv %b cv %b av %b cs %b exp 1 0 0 0",
                     m_if.valid, c_if.valid, a_if.valid, m_if.cs);
        else pass_cnt++;
        spurious = 0;
        step();
    endtask

    task automatic test_back_to_back();
        int n;
        int base;
        base = txn_cnt;
        c_if.cs = 1; c_if.addr = 32'h100;
        step();
        wait_valid(100, n);
        total_cnt++;
        if ({c_if.valid, c_if.rdata} !== {1'b1, 32'h1234_5678})
            $display("FAIL b2b_first: got cv %b rd %h exp 1 12345678", c_if.valid, c_if.rdata);
        else pass_cnt++;
        c_if.addr = 32'h104;
        step();
        total_cnt++;
        if (m_if.cs !== 1'b0) $display("FAIL b2b_gap: got m_cs %b exp 0", m_if.cs);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({m_if.cs, m_if.addr} !== {1'b1, 32'h104})
            $display("FAIL b2b_second: got cs %b addr %h exp 1 104", m_if.cs, m_if.addr);
        else pass_cnt++;
        wait_valid(100, n);
        total_cnt++;
        if ({n, c_if.rdata} !== {32'd2, 32'hA5A5_0001})
            $display("FAIL b2b_resp: got wait %0d rd %h exp 2 a5a50001", n, c_if.rdata);
        else pass_cnt++;
        c_if.cs = 0;
        step();
        step();
        total_cnt++;
        if (txn_cnt - base !== 2) $display("FAIL b2b_count: got %0d txns exp 2", txn_cnt - base);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_busy();
        int n;
        c_if.cs = 1; c_if.addr = 32'h100;
        step();
        step();
        reset_n = 0;
        #1;
        total_cnt++;
        if ({m_if.cs, c_if.valid} !== 2'b00)
            $display("FAIL rst_mid_drop: got cs %b cv %b exp 0 0", m_if.cs, c_if.valid);
        else pass_cnt++;
        step();
        step();
        total_cnt++;
        if ({m_if.cs, c_if.valid, a_if.valid} !== 3'b000)
            $display("FAIL rst_mid_quiet: got cs %b cv %b av %b exp 000", m_if.cs, c_if.valid, a_if.valid);
        else pass_cnt++;
        reset_n = 1;
        step();
        total_cnt++;
        if ({m_if.cs, m_if.addr} !== {1'b1, 32'h100})
            $display("FAIL rst_mid_regrant: got cs %b addr %h exp 1 100", m_if.cs, m_if.addr);
        else pass_cnt++;
        wait_valid(100, n);
        total_cnt++;
        if ({c_if.valid, c_if.rdata} !== {1'b1, 32'h1234_5678})
            $display("FAIL rst_mid_resp: got cv %b rd %h exp 1 12345678", c_if.valid, c_if.rdata);
        else pass_cnt++;
        c_if.cs = 0;
        step();
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        do_reset();
        mem_hang = 1;
        c_if.cs = 1; c_if.addr = 32'h100;
        step();
        wait_valid(200, n);
        total_cnt++;
        if (n !== TIMEOUT_CYC - 1) $display("FAIL to_cycles: got %0d exp %0d", n, TIMEOUT_CYC - 1);
        else pass_cnt++;
        total_cnt++;
        if ({c_if.valid, c_if.rdata, a_if.valid, m_if.cs} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1})
            $display("FAIL to_resp: got cv %b rd %h av %b cs %b exp 1 deadbeef 0 1",
                     c_if.valid, c_if.rdata, a_if.valid, m_if.cs);
        else pass_cnt++;
        c_if.cs = 0;
        step();
        total_cnt++;
        if ({err, m_if.cs, c_if.valid} !== 3'b100)
            $display("FAIL to_err_set: got err %b cs %b cv %b exp 1 0 0", err, m_if.cs, c_if.valid);
        else pass_cnt++;
        step();
        step();
        total_cnt++;
        if (err !== 1'b1) $display("FAIL to_err_sticky: got %b exp 1", err);
        else pass_cnt++;
    endtask
`else
    task automatic test_err_tied();
        total_cnt++;
        if (err !== 1'b0) $display("FAIL err_tied: got %b exp 0", err);
        else pass_cnt++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        test_reset();
        test_core_read();
        test_tie();
        test_acc_write();
        test_idle_valid();
        test_back_to_back();
        test_reset_mid_busy();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_err_tied();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
